// File: rtl/ppu_pkg.sv
// Shared PPU sprite-fetch definitions: per-slot phase encoding, fetch FSM
// states and default sizing for the sprite fetch controller.
package ppu_pkg;

  localparam int unsigned NUM_SLOTS_DEF = 8;
  localparam int unsigned PT_ADDR_W_DEF = 14;

  // Tile fetched for empty slots so timing and memory traffic stay constant
  localparam logic [7:0] EMPTY_TILE = 8'hFF;

  typedef enum logic [2:0] {
    PH_Y        = 3'd0,
    PH_TILE     = 3'd1,
    PH_ATTR     = 3'd2,
    PH_X        = 3'd3,
    PH_PT0_ADDR = 3'd4,
    PH_PT0_DATA = 3'd5,
    PH_PT1_ADDR = 3'd6,
    PH_PT1_DATA = 3'd7
  } fetch_phase_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sprite_pt_addr_gen.sv
// Sprite row / vertical-flip / pattern address generation.
// Define SPRITE_8X16_EN to honour sprite_size (8x16 sprites); default is 8x8 only.
module sprite_pt_addr_gen
  import ppu_pkg::*;
#(
  parameter int unsigned PT_ADDR_W = PT_ADDR_W_DEF
) (
  input  logic [7:0]           scanline,
  input  logic [7:0]           y,
  input  logic [7:0]           tile,
  input  logic                 vflip,
  input  logic                 sprite_size,
  input  logic                 spr_pt_sel,
  input  logic                 plane,
  input  logic                 live,
  output logic [PT_ADDR_W-1:0] addr
);

  logic [7:0]  row_raw;
  logic [7:0]  row;
  logic [7:0]  tile_eff;
  logic [13:0] addr14;
  logic        unused_bits;

  always_comb begin
    row_raw  = scanline - y;
    tile_eff = live ? tile : EMPTY_TILE;
`ifdef SPRITE_8X16_EN
    row    = live ? (row_raw ^ (vflip ? (sprite_size ? 8'h0F : 8'h07) : 8'h00)) : '0;
    // 8x16: tile bit 0 selects the table, row bit 3 selects the lower tile
    addr14 = sprite_size ? {1'b0, tile_eff[0], tile_eff[7:1], row[3], plane, row[2:0]}
                         : {1'b0, spr_pt_sel, tile_eff, plane, row[2:0]};
`else
    row    = live ? (row_raw ^ (vflip ? 8'h07 : 8'h00)) : '0;
    addr14 = {1'b0, spr_pt_sel, tile_eff, plane, row[2:0]};
`endif
    addr = PT_ADDR_W'(addr14);
  end

`ifdef SPRITE_8X16_EN
  assign unused_bits = ^row[7:4];
`else
  assign unused_bits = ^{row[7:3], sprite_size};
`endif

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Per-line sprite fetch sequencer: 8 dots per slot reading secondary OAM and
// two pattern planes. Optional SPRITE_8X16_EN enables 8x16 sprite addressing.
module sprite_fetch_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned PT_ADDR_W = PT_ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_start,
  input  logic [7:0]           scanline,
  input  logic [3:0]           sprite_count,
  input  logic                 sprite_size,
  input  logic                 spr_pt_sel,
  output logic [4:0]           soam_addr,
  input  logic [7:0]           soam_din,
  output logic [PT_ADDR_W-1:0] pt_addr,
  output logic                 pt_rd,
  output logic [NUM_SLOTS-1:0] slot_attr_ld,
  output logic [NUM_SLOTS-1:0] slot_x_ld,
  output logic [NUM_SLOTS-1:0] slot_pattern0_ld,
  output logic [NUM_SLOTS-1:0] slot_pattern1_ld,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 fetch_busy,
  output logic                 fetch_done
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

  fetch_state_e         state, state_n;
  fetch_phase_e         phase;
  logic [2:0]           slot;
  logic [7:0]           y_q;
  logic [7:0]           tile_q;
  logic                 vflip_q;
  logic [NUM_SLOTS-1:0] slot_valid_q;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic [3:0]           cnt_eff;
  logic                 slot_live;
  logic                 last_cycle;
  logic [PT_ADDR_W-1:0] gen_addr;

  assign cnt_eff    = (sprite_count > 4'd8) ? 4'd8 : sprite_count;
  assign slot_live  = ({1'b0, slot} < cnt_eff);
  assign slot_oh    = NUM_SLOTS'(1) << slot;
  assign last_cycle = (phase == PH_PT1_DATA) && (slot == LAST_SLOT);
  assign slot_valid = slot_valid_q;

  sprite_pt_addr_gen #(
    .PT_ADDR_W (PT_ADDR_W)
  ) u_addr_gen (
    .scanline    (scanline),
    .y           (y_q),
    .tile        (tile_q),
    .vflip       (vflip_q),
    .sprite_size (sprite_size),
    .spr_pt_sel  (spr_pt_sel),
    .plane       (phase[1]),
    .live        (slot_live),
    .addr        (gen_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      phase        <= PH_Y;
      slot         <= '0;
      y_q          <= '0;
      tile_q       <= '0;
      vflip_q      <= 1'b0;
      slot_valid_q <= '0;
    end else begin
      state <= state_n;
      if (fetch_start) begin
        phase <= PH_Y;
        slot  <= '0;
      end else if (state == ST_FETCH) begin
        phase <= fetch_phase_e'(phase + 3'd1);
        if (phase == PH_PT1_DATA)
          slot <= (slot == LAST_SLOT) ? '0 : slot + 3'd1;
        // soam_din lags soam_addr by one cycle, so each byte lands a phase late
        case (phase)
          PH_TILE:     y_q                <= soam_din;
          PH_ATTR:     tile_q             <= soam_din;
          PH_X:        vflip_q            <= soam_din[7];
          PH_PT1_DATA: slot_valid_q[slot] <= slot_live;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n          = state;
    soam_addr        = '0;
    pt_addr          = '0;
    pt_rd            = 1'b0;
    slot_attr_ld     = '0;
    slot_x_ld        = '0;
    slot_pattern0_ld = '0;
    slot_pattern1_ld = '0;
    fetch_busy       = 1'b0;
    fetch_done       = 1'b0;

    case (state)
      ST_IDLE:  if (fetch_start) state_n = ST_FETCH;
      ST_FETCH: if (!fetch_start && last_cycle) state_n = ST_DONE;
      ST_DONE:  state_n = fetch_start ? ST_FETCH : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    if (state == ST_FETCH) begin
      fetch_busy = 1'b1;
      if (!phase[2])
        soam_addr = {slot, phase[1:0]};
      case (phase)
        PH_X:        slot_attr_ld     = slot_oh;
        PH_PT0_ADDR: begin
          slot_x_ld = slot_oh;
          pt_rd     = 1'b1;
        end
        PH_PT0_DATA: slot_pattern0_ld = slot_oh;
        PH_PT1_ADDR: pt_rd            = 1'b1;
        PH_PT1_DATA: slot_pattern1_ld = slot_oh;
        default: ;
      endcase
      if (pt_rd)
        pt_addr = gen_addr;
    end

    if (state == ST_DONE)
      fetch_done = 1'b1;
  end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Directed bench for sprite_fetch_ctrl: cycle-logged fetch runs with
// hand-computed addresses, strobe timing, restart and mid-fetch reset.
module tb_sprite_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [7:0]  scanline;
  logic [3:0]  sprite_count;
  logic        sprite_size;
  logic        spr_pt_sel;
  logic [4:0]  soam_addr;
  logic [7:0]  soam_din = '0;
  logic [13:0] pt_addr;
  logic        pt_rd;
  logic [7:0]  slot_attr_ld, slot_x_ld, slot_pattern0_ld, slot_pattern1_ld;
  logic [7:0]  slot_valid;
  logic        fetch_busy, fetch_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  soam_mem [0:31];
  logic [4:0]  soam_l   [0:127];
  logic [13:0] pa_l     [0:127];
  logic        rd_l     [0:127];
  logic        busy_l   [0:127];
  logic [7:0]  attr_l   [0:127];
  logic [7:0]  x_l      [0:127];
  logic [7:0]  p0_l     [0:127];
  logic [7:0]  p1_l     [0:127];
  logic [7:0]  sv_l     [0:127];

  int done_cyc, done_cnt, busy_cnt, rd_cnt, strb_cnt, s2_early, s2_total;

  always #5 clk = ~clk;

  always @(posedge clk) soam_din <= soam_mem[soam_addr];

  sprite_fetch_ctrl #(
    .NUM_SLOTS (8),
    .PT_ADDR_W (14)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_start      (fetch_start),
    .scanline         (scanline),
    .sprite_count     (sprite_count),
    .sprite_size      (sprite_size),
    .spr_pt_sel       (spr_pt_sel),
    .soam_addr        (soam_addr),
    .soam_din         (soam_din),
    .pt_addr          (pt_addr),
    .pt_rd            (pt_rd),
    .slot_attr_ld     (slot_attr_ld),
    .slot_x_ld        (slot_x_ld),
    .slot_pattern0_ld (slot_pattern0_ld),
    .slot_pattern1_ld (slot_pattern1_ld),
    .slot_valid       (slot_valid),
    .fetch_busy       (fetch_busy),
    .fetch_done       (fetch_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [7:0] y, input logic [7:0] tile,
                          input logic [7:0] attr, input logic [7:0] x);
    soam_mem[s*4+0] = y;
    soam_mem[s*4+1] = tile;
    soam_mem[s*4+2] = attr;
    soam_mem[s*4+3] = x;
  endtask

  // Pulse fetch_start, then log ncyc cycles. Cycle c is the c-th cycle after
  // the start edge; restart_at / rst_at drive fetch_start / rst low into the
  // edge that ends cycle c.
  task automatic run(input int ncyc, input int restart_at, input int rst_at);
    int s2;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; rd_cnt = 0;
    strb_cnt = 0; s2_early = 0; s2_total = 0;
    @(negedge clk);
    fetch_start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      soam_l[c] = soam_addr;  pa_l[c] = pt_addr;  rd_l[c] = pt_rd;
      busy_l[c] = fetch_busy; attr_l[c] = slot_attr_ld; x_l[c] = slot_x_ld;
      p0_l[c] = slot_pattern0_ld; p1_l[c] = slot_pattern1_ld; sv_l[c] = slot_valid;
      check("onehot0", {$onehot0(slot_attr_ld), $onehot0(slot_x_ld),
                        $onehot0(slot_pattern0_ld), $onehot0(slot_pattern1_ld)}, 4'hF);
      if (fetch_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      busy_cnt += int'(fetch_busy);
      rd_cnt   += int'(pt_rd);
      strb_cnt += $countones(slot_attr_ld) + $countones(slot_x_ld)
                + $countones(slot_pattern0_ld) + $countones(slot_pattern1_ld);
      s2 = int'(slot_attr_ld[2]) + int'(slot_x_ld[2])
         + int'(slot_pattern0_ld[2]) + int'(slot_pattern1_ld[2]);
      if (restart_at > 0 && c > restart_at) begin
        s2_total += s2;
        if (c <= restart_at + 16) s2_early += s2;
      end
      fetch_start = (c == restart_at);
      rst         = (c != rst_at);
    end
    fetch_start = 1'b0;
    rst         = 1'b1;
  endtask

  initial begin
    rst = 1'b0; fetch_start = 1'b0; scanline = '0; sprite_count = '0;
    sprite_size = 1'b0; spr_pt_sel = 1'b0;
    for (int i = 0; i < 32; i++) soam_mem[i] = '0;
    repeat (2) @(negedge clk);

    check("reset_ctrl", {fetch_busy, fetch_done, pt_rd}, 3'b000);
    check("reset_addr", {soam_addr, pt_addr}, '0);
    check("reset_strobes", {slot_attr_ld, slot_x_ld, slot_pattern0_ld, slot_pattern1_ld}, '0);
    check("reset_valid", slot_valid, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Full line: all slots live; slot 1 vertically flipped
    for (int s = 0; s < 8; s++) set_slot(s, 8'd16, 8'h42, 8'h00, 8'(s * 8));
    set_slot(1, 8'd18, 8'h10, 8'h80, 8'd8);
    scanline = 8'd20; sprite_count = 4'd8; spr_pt_sel = 1'b1; sprite_size = 1'b0;
    run(70, 0, 0);
    check("t1_soam_y_addr", soam_l[2], 5'h01);
    check("t1_soam_s1_x", soam_l[12], 5'h07);
    check("t1_attr_ld", attr_l[4], 8'h01);
    check("t1_x_ld", x_l[5], 8'h01);
    check("t1_rd_ph4", rd_l[5], 1'b1);
    check("t1_pt0_addr", pa_l[5], 14'h1424);
    check("t1_pat0_ld", p0_l[6], 8'h01);
    check("t1_pt1_addr", pa_l[7], 14'h142C);
    check("t1_pat1_ld", p1_l[8], 8'h01);
    check("t1_s1_vflip_pt0", pa_l[13], 14'h1105);
    check("t1_s1_vflip_pt1", pa_l[15], 14'h110D);
    check("t1_s7_pat1_ld", p1_l[64], 8'h80);
    check("t1_busy_cycles", busy_cnt, 64);
    check("t1_done_cycle", done_cyc, 65);
    check("t1_done_count", done_cnt, 1);
    check("t1_rd_count", rd_cnt, 16);
    check("t1_valid", slot_valid, 8'hFF);

    // Three live sprites; slots 3..7 fetch the empty tile
    sprite_count = 4'd3;
    run(70, 0, 0);
    check("t2_s2_pt0", pa_l[21], 14'h1424);
    check("t2_s3_pt0_empty", pa_l[29], 14'h1FF0);
    check("t2_s3_pt1_empty", pa_l[31], 14'h1FF8);
    check("t2_s7_attr_ld", attr_l[60], 8'h80);
    check("t2_valid_before_s3", sv_l[32], 8'hFF);
    check("t2_valid_after_s3", sv_l[33], 8'hF7);
    check("t2_strobe_total", strb_cnt, 32);
    check("t2_rd_count", rd_cnt, 16);
    check("t2_valid", slot_valid, 8'h07);

    sprite_count = 4'd12;
    run(70, 0, 0);
    check("t2_count_clamp", slot_valid, 8'hFF);

    // Row 9 with vflip: 8x16 gives row 6 top half, 8x8 gives row[2:0]=6 of tile 43
    set_slot(0, 8'd11, 8'h43, 8'h80, 8'd0);
    sprite_count = 4'd1; sprite_size = 1'b1;
    run(70, 0, 0);
`ifdef SPRITE_8X16_EN
    check("t3_pt0_addr", pa_l[5], 14'h1426);
    check("t3_pt1_addr", pa_l[7], 14'h142E);
`else
    check("t3_pt0_addr", pa_l[5], 14'h1436);
    check("t3_pt1_addr", pa_l[7], 14'h143E);
`endif
    sprite_size = 1'b0;

    // Restart during slot 2
    set_slot(0, 8'd16, 8'h42, 8'h00, 8'd0);
    sprite_count = 4'd8;
    run(90, 20, 0);
    check("t4_attr_before", attr_l[20], 8'h04);
    check("t4_soam_before", soam_l[20], 5'h0B);
    check("t4_soam_restart", soam_l[21], 5'h00);
    check("t4_pt0_restart", pa_l[25], 14'h1424);
    check("t4_s2_early", s2_early, 0);
    check("t4_s2_total", s2_total, 4);
    check("t4_done_cycle", done_cyc, 85);
    check("t4_done_count", done_cnt, 1);
    check("t4_busy_cycles", busy_cnt, 84);

    // Reset mid-fetch, with a fetch_start in the same cycle that must be ignored
    run(70, 30, 30);
    check("t5_busy_before", busy_l[30], 1'b1);
    check("t5_busy_after", busy_l[31], 1'b0);
    check("t5_valid_after", sv_l[31], 8'h00);
    check("t5_addr_after", {soam_l[31], pa_l[31], rd_l[31]}, '0);
    check("t5_strobes_after", {attr_l[31], x_l[31], p0_l[31], p1_l[31]}, '0);
    check("t5_busy_cycles", busy_cnt, 30);
    check("t5_no_done", done_cnt, 0);
    check("t5_valid_end", slot_valid, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
